// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: inferred memory with registered read, pointer/flag control, occupancy count.
// Optional sticky overflow/underflow error flags are compiled in when SYNC_FIFO_ERR_EN is defined.
module sync_fifo_ctrl #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SYNC_FIFO_ERR_EN
  input  logic             err_clr,
  output logic             overflow,
  output logic             underflow,
`endif
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rvalid,
  output logic             full,
  output logic             empty,
  output logic             afull,
  output logic             aempty,
  output logic [ASIZE:0]   count
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] AFULL_LIM  = AFULL_TH[ASIZE:0];
  localparam logic [ASIZE:0] AEMPTY_LIM = AEMPTY_TH[ASIZE:0];

  logic [DSIZE-1:0] mem [DEPTH];

  logic [ASIZE:0] wptr_reg, rptr_reg;
  logic [ASIZE:0] wptr_next, rptr_next, count_next;
  logic           push_ok, pop_ok;

  // Acceptance uses the registered flags, so a push into a full FIFO is dropped
  // even when a pop is accepted on the same edge.
  always_comb begin
    push_ok    = winc && !full;
    pop_ok     = rinc && !empty;
    wptr_next  = push_ok ? wptr_reg + 1'b1 : wptr_reg;
    rptr_next  = pop_ok  ? rptr_reg + 1'b1 : rptr_reg;
    count_next = wptr_next - rptr_next;
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr_reg[ASIZE-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      afull    <= 1'b0;
      aempty   <= 1'b1;
      rdata    <= '0;
      rvalid   <= 1'b0;
    end else begin
      wptr_reg <= wptr_next;
      rptr_reg <= rptr_next;
      count    <= count_next;
      // count can only reach DEPTH (MSB set) when every entry is occupied
      full     <= count_next[ASIZE];
      empty    <= (count_next == '0);
      afull    <= (count_next >= AFULL_LIM);
      aempty   <= (count_next <= AEMPTY_LIM);
      rvalid   <= pop_ok;
      if (pop_ok) begin
        rdata <= mem[rptr_reg[ASIZE-1:0]];
      end
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  // Sticky error flags; a new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc && full) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (rinc && empty) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: queue-based reference model checked every cycle,
// plus directed transactions with literal expectations.
module tb_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       winc = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       rinc = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rdata;
  logic       rvalid, full, empty, afull, aempty;
  logic [4:0] count;
`ifdef SYNC_FIFO_ERR_EN
  logic       overflow, underflow;
`endif

  int total = 0;
  int bad = 0;

  // reference model state
  logic [7:0] mq[$];
  logic [7:0] m_rdata = 8'h00;
  logic       m_rvalid = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;
  int         m_pushes = 0;
  bit         cmp_en = 1'b0;

  sync_fifo_ctrl #(.DSIZE(8), .ASIZE(4), .AFULL_TH(12), .AEMPTY_TH(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef SYNC_FIFO_ERR_EN
    .err_clr(err_clr),
    .overflow(overflow),
    .underflow(underflow),
`endif
    .winc(winc),
    .wdata(wdata),
    .rinc(rinc),
    .rdata(rdata),
    .rvalid(rvalid),
    .full(full),
    .empty(empty),
    .afull(afull),
    .aempty(aempty),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: occupancy is the queue length; a pop returns the oldest entry.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_rdata  = 8'h00;
        m_rvalid = 1'b0;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        m_pushes = 0;
      end else begin
        bit was_full, was_empty;
        was_full  = (mq.size() == 16);
        was_empty = (mq.size() == 0);
        if (winc && was_full) m_ovf = 1'b1;
        else if (err_clr)     m_ovf = 1'b0;
        if (rinc && was_empty) m_udf = 1'b1;
        else if (err_clr)      m_udf = 1'b0;
        m_rvalid = rinc && !was_empty;
        if (m_rvalid) m_rdata = mq.pop_front();
        if (winc && !was_full) begin
          mq.push_back(wdata);
          m_pushes++;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        int n;
        n = mq.size();
        chk("cyc_count",  32'(count),  32'(n));
        chk("cyc_full",   32'(full),   32'(n == 16));
        chk("cyc_empty",  32'(empty),  32'(n == 0));
        chk("cyc_afull",  32'(afull),  32'(n >= 12));
        chk("cyc_aempty", 32'(aempty), 32'(n <= 2));
        chk("cyc_rvalid", 32'(rvalid), 32'(m_rvalid));
        chk("cyc_rdata",  32'(rdata),  32'(m_rdata));
`ifdef SYNC_FIFO_ERR_EN
        chk("cyc_overflow",  32'(overflow),  32'(m_ovf));
        chk("cyc_underflow", 32'(underflow), 32'(m_udf));
`endif
      end
    end
  end

  // One transaction: drive at a falling edge, return at the next falling edge.
  task automatic step(input logic w, input logic [7:0] wd, input logic r);
    winc  = w;
    wdata = wd;
    rinc  = r;
    @(negedge clk);
    winc = 1'b0;
    rinc = 1'b0;
    $display("txn w=%0d wd=%02h r=%0d -> count=%0d rdata=%02h rvalid=%0d full=%0d empty=%0d",
             w, wd, r, count, rdata, rvalid, full, empty);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1. reset state
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_aempty", 32'(aempty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_afull", 32'(afull), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_rvalid", 32'(rvalid), 0);

    // 2. fill
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b0);
      if (i == 1)  chk("fill_aempty_off", 32'(aempty), 1);
      if (i == 2)  chk("fill_aempty_off3", 32'(aempty), 0);
      if (i == 10) chk("fill_afull_11", 32'(afull), 0);
      if (i == 11) chk("fill_afull_12", 32'(afull), 1);
      if (i == 14) chk("fill_full_15", 32'(full), 0);
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 16);
    step(1'b1, 8'hAA, 1'b0);
    chk("ovf_push_count", 32'(count), 16);
`ifdef SYNC_FIFO_ERR_EN
    chk("ovf_flag", 32'(overflow), 1);
`endif

    // 3. drain
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("drain_rdata", 32'(rdata), 32'(8'h10 + i));
      chk("drain_rvalid", 32'(rvalid), 1);
    end
    chk("drain_empty", 32'(empty), 1);
    step(1'b0, 8'h00, 1'b1);
    chk("udf_rdata_hold", 32'(rdata), 32'h1F);
    chk("udf_rvalid", 32'(rvalid), 0);
`ifdef SYNC_FIFO_ERR_EN
    chk("udf_flag", 32'(underflow), 1);
    err_clr = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    err_clr = 1'b0;
    chk("err_clr_ovf", 32'(overflow), 0);
    chk("err_clr_udf", 32'(underflow), 0);
`endif

    // 4a. simultaneous push+pop mid-range
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    step(1'b1, 8'h35, 1'b1);
    chk("pp_mid_count", 32'(count), 5);
    chk("pp_mid_rdata", 32'(rdata), 32'h30);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);
    chk("pp_mid_last", 32'(rdata), 32'h35);

    // 4b. simultaneous push+pop when full
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    step(1'b1, 8'hEE, 1'b1);
    chk("pp_full_count", 32'(count), 15);
    chk("pp_full_rdata", 32'(rdata), 32'h40);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("pp_full_drain", 32'(rdata), 32'(8'h41 + i));
    end
    chk("pp_full_empty", 32'(empty), 1);

    // 4c. simultaneous push+pop when empty
    step(1'b1, 8'h66, 1'b1);
    chk("pp_empty_count", 32'(count), 1);
    chk("pp_empty_rvalid", 32'(rvalid), 0);
    chk("pp_empty_rdata", 32'(rdata), 32'h4F);
    step(1'b0, 8'h00, 1'b1);
    chk("pp_empty_pop", 32'(rdata), 32'h66);

    // 5. interleaved traffic with random idle gaps
    begin
      int base;
      base = m_pushes;
      for (int i = 0; i < 40; i++) begin
        step(1'b1, 8'(8'h80 + i), (i % 4) != 0);
        repeat ($urandom_range(0, 2)) step(1'b0, 8'h00, 1'b0);
      end
      chk("wrap_pushes_ge32", 32'(m_pushes - base >= 32), 1);
      for (int i = 0; i < 17; i++) step(1'b0, 8'h00, 1'b1);
      chk("wrap_drained", 32'(empty), 1);
    end

    // 6. asynchronous reset mid-cycle at count=7
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    chk("pre_rst_count", 32'(count), 7);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_aempty", 32'(aempty), 1);
    chk("arst_full", 32'(full), 0);
    chk("arst_rdata", 32'(rdata), 0);
    chk("arst_rvalid", 32'(rvalid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h55, 1'b0);
    chk("post_rst_count", 32'(count), 1);
    step(1'b0, 8'h00, 1'b1);
    chk("post_rst_rdata", 32'(rdata), 32'h55);
    chk("post_rst_rvalid", 32'(rvalid), 1);

    step(1'b0, 8'h00, 1'b0);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
